// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with HI/LO registers.
//
// Sits in the E stage beside the ALU. Arithmetic ops (mult/multu/div/divu)
// latch their operands at start, stay busy for a fixed number of cycles and
// then commit {HI,LO} in one step. mthi/mtlo write HI/LO directly when idle.
//
// Optional feature (compile-time macro MDU_DIV_ZERO_GUARD_EN):
//   defined     - div/divu by zero runs the full busy window and leaves HI/LO unchanged.
//   not defined - div/divu by zero commits LO=0xFFFFFFFF, HI=dividend.
//
// Ports:
//   clk       in   1   clock, rising edge
//   reset     in   1   synchronous active-high reset
//   start     in   1   E-stage instruction is an MD op
//   md_op     in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//   rs_val    in   32  rs operand (dividend / multiplicand / mthi-mtlo source)
//   rt_val    in   32  rt operand (divisor / multiplier)
//   d_md_use  in   1   D-stage instruction uses the MD unit
//   hi_out    out  32  HI register
//   lo_out    out  32  LO register
//   busy      out  1   arithmetic op in flight
//   stall_md  out  1   stall request to the hazard controller (combinational)

`timescale 1ns / 1ps

module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        stall_md
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;   // bit 1: divide, bit 0: unsigned
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic is_arith;
  logic launch;
  logic done;

  assign is_arith = start & (md_op <= 3'd3);
  assign launch   = (state_q == StIdle) & is_arith;
  assign done     = (state_q == StRun) & (cnt_q == CntW'(1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (is_arith) state_d = StRun;
      StRun:  if (done)     state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (state_q == StRun);
    stall_md = d_md_use & ((state_q == StRun) | is_arith);
  end

  // ---------------------------------------------------------------------------
  // Arithmetic on the latched operands
  // ---------------------------------------------------------------------------
  logic signed [63:0] a_sx, b_sx;
  logic [63:0]        prod_s, prod_u;
  logic               a_neg, b_neg, div_zero;
  logic [31:0]        a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [63:0]        result;
  logic               commit_en;

  always_comb begin
    a_sx   = {{32{a_q[31]}}, a_q};
    b_sx   = {{32{b_q[31]}}, b_q};
    prod_s = a_sx * b_sx;
    prod_u = {32'b0, a_q} * {32'b0, b_q};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    a_neg    = ~op_q[0] & a_q[31];
    b_neg    = ~op_q[0] & b_q[31];
    a_mag    = a_neg ? -a_q : a_q;
    b_mag    = b_neg ? -b_q : b_q;
    div_zero = (b_q == 32'd0);
    q_mag    = div_zero ? 32'd0 : a_mag / b_mag;
    r_mag    = div_zero ? 32'd0 : a_mag % b_mag;
    quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem      = a_neg ? -r_mag : r_mag;

    if (!op_q[1]) begin
      result = op_q[0] ? prod_u : prod_s;
    end else if (div_zero) begin
      result = {a_q, 32'hFFFF_FFFF};
    end else begin
      result = {rem, quot};
    end

`ifdef MDU_DIV_ZERO_GUARD_EN
    commit_en = ~(op_q[1] & div_zero);
`else
    commit_en = 1'b1;
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;

    if (state_q == StIdle) begin
      if (launch) begin
        op_d  = md_op[1:0];
        a_d   = rs_val;
        b_d   = rt_val;
        cnt_d = md_op[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
      end else if (start && md_op == 3'd4) begin
        hi_d = rs_val;
      end else if (start && md_op == 3'd5) begin
        lo_d = rs_val;
      end
    end else begin
      // Any start seen while running (including mthi/mtlo) is ignored.
      cnt_d = cnt_q - CntW'(1);
      if (done && commit_en) begin
        hi_d = result[63:32];
        lo_d = result[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
